// File: rtl/modulo_controlador_contador_7_bits.sv
// modulo_controlador_contador_7_bits
// Up/down button controller for an external 7-bit counter. Turns level
// requests into one-cycle enable pulses with auto-repeat, and refuses any
// step that would take the counter past LIMITE_MAX or below zero.
//
// Ports
//   clk       in   single clock, rising edge
//   clr       in   asynchronous active-high reset
//   btn_up    in   increment request (level, synchronous to clk)
//   btn_down  in   decrement request (level, synchronous to clk)
//   q         in   [6:0] current counter value
//   enable    out  one-cycle count pulse
//   up_down   out  counter direction, 1 = up, held between pulses
//   cheio     out  q >= LIMITE_MAX (combinational)
//   vazio     out  q == 0 (combinational)
//   erro      out  one-cycle pulse when a request is refused at a limit
//
// state     | meaning
// OCIOSO    | idle, waiting for a single request
// PULSO     | enable high for this one cycle
// ESPERA    | request held, timing the next auto-repeat
// BLOQUEADO | refused or conflicting request, wait for both buttons low
//
// ATRASO_REPETICAO and PERIODO_REPETICAO are legal from 3 to 65535.

module modulo_controlador_contador_7_bits #(
  parameter logic [6:0] LIMITE_MAX        = 7'd99,
  parameter int         ATRASO_REPETICAO  = 50,
  parameter int         PERIODO_REPETICAO = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [6:0] q,
  output logic       enable,
  output logic       up_down,
  output logic       cheio,
  output logic       vazio,
  output logic       erro
);

  typedef enum logic [1:0] {
    OCIOSO,
    PULSO,
    ESPERA,
    BLOQUEADO
  } estado_t;

  // The timer is cleared in PULSO, so ESPERA starts at 0 one cycle after the
  // pulse; the decision to pulse again is taken one cycle before the pulse.
  // Hence the terminal count is the interval minus two.
  localparam logic [15:0] TC_ATRASO  = 16'(ATRASO_REPETICAO - 2);
  localparam logic [15:0] TC_PERIODO = 16'(PERIODO_REPETICAO - 2);

  estado_t     estado;
  logic [15:0] timer;
  logic        repetindo;
  logic        pedido_ativo;
  logic        pedido_oposto;
  logic        no_limite;
  logic        fim_timer;

  assign cheio = (q >= LIMITE_MAX);
  assign vazio = (q == 7'd0);

  // up_down holds the direction of the request being serviced
  assign pedido_ativo  = up_down ? btn_up : btn_down;
  assign pedido_oposto = up_down ? btn_down : btn_up;
  assign no_limite     = up_down ? cheio : vazio;
  assign fim_timer     = (timer == (repetindo ? TC_PERIODO : TC_ATRASO));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      estado    <= OCIOSO;
      enable    <= 1'b0;
      up_down   <= 1'b1;
      erro      <= 1'b0;
      timer     <= '0;
      repetindo <= 1'b0;
    end else begin
      enable <= 1'b0;
      erro   <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (btn_up && btn_down) begin
            estado <= BLOQUEADO;
          end else if (btn_up) begin
            if (cheio) begin
              erro   <= 1'b1;
              estado <= BLOQUEADO;
            end else begin
              up_down   <= 1'b1;
              enable    <= 1'b1;
              repetindo <= 1'b0;
              estado    <= PULSO;
            end
          end else if (btn_down) begin
            if (vazio) begin
              erro   <= 1'b1;
              estado <= BLOQUEADO;
            end else begin
              up_down   <= 1'b0;
              enable    <= 1'b1;
              repetindo <= 1'b0;
              estado    <= PULSO;
            end
          end
        end

        PULSO: begin
          timer  <= '0;
          estado <= ESPERA;
        end

        ESPERA: begin
          if (pedido_oposto) begin
            estado <= BLOQUEADO;
          end else if (!pedido_ativo) begin
            estado <= OCIOSO;
          end else if (fim_timer) begin
            // q may have moved since the last pulse; recheck before repeating
            if (no_limite) begin
              erro   <= 1'b1;
              estado <= BLOQUEADO;
            end else begin
              enable    <= 1'b1;
              repetindo <= 1'b1;
              estado    <= PULSO;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

        BLOQUEADO: begin
          if (!btn_up && !btn_down) begin
            estado <= OCIOSO;
          end
        end

        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
